run_step_ctrl: RTL and testbench
================================

# run_step_ctrl

Execution controller that sits upstream of the CPU core and produces its `work_ena` gate from the five board push-buttons. It synchronises and debounces the raw buttons and generates one-cycle press pulses. A mode FSM (PAUSE / RUN / SLOW / STEP) decides on which clock cycles the core may advance. It also keeps a wrapping count of enabled cycles and a display-page selector for the seven-segment front end.

## Interface
- `DB_TICKS`, default 1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- `SLOW_DIV`, default 50_000_000: period, in clocks, of one `work_ena` pulse in SLOW mode. Must be ≥ 2.
- `clk`  in  1  system clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock domain only.
- `btnC`, `btnU`, `btnL`, `btnR`, `btnD`  in  1 each  raw asynchronous button levels; 1 = pressed.
- `work_ena`  out  1  registered; CPU advances one cycle on each clock where it is 1.
- `mode`  out  2  registered; 00 PAUSE, 01 RUN, 10 STEP, 11 SLOW.
- `btn_pulse`  out  5  registered one-cycle press pulses. Bit order {D,R,L,U,C}, bit 0 = C.
- `disp_sel`  out  2  registered display page, 0–3.
- `cycle_cnt`  out  16  registered count of cycles with `work_ena`=1.

## Operation
- **Synchroniser:** each button passes through a 2-flop synchroniser giving `sync[i]`.
- **Debounce:**
  - Per-button counter, width `$clog2(DB_TICKS+1)`, plus a `stable[i]` flag.
  - While `sync[i]` ≠ `stable[i]`, the counter increments.
  - When the counter reaches `DB_TICKS`, `stable[i]` takes `sync[i]` and the counter clears.
  - Any cycle with `sync[i]` = `stable[i]` clears the counter, so glitches shorter than `DB_TICKS` are rejected.
- **Edge detect:** `btn_pulse[i]` is 1 for exactly one cycle after `stable[i]` goes 0→1. Releases produce no pulse.
- **Mode FSM.** The FSM acts on the `btn_pulse` value present in the current cycle. When several pulses are high together, priority is C > U > R; L and D are handled independently of the FSM.
  - PAUSE: C → RUN; U → SLOW; R → STEP.
  - RUN: C → PAUSE; U → SLOW.
  - SLOW: C → PAUSE; U → RUN.
  - STEP: unconditionally → PAUSE on the next edge, ignoring all pulses.
- **work_ena:**
  - Next-state 1 in RUN and in STEP.
  - In SLOW, 1 only when the slow counter = `SLOW_DIV`−1.
  - 0 in PAUSE.
- **Slow counter:**
  - Counts 0..`SLOW_DIV`−1 and wraps only while in SLOW.
  - Forced to 0 on every transition into SLOW.
- **disp_sel:**
  - D pulse increments it (3→0); L pulse decrements it (0→3).
  - L and D in the same cycle leave it unchanged.
  - Independent of mode.
- **cycle_cnt:** +1 on each clock where `work_ena`=1; wraps 0xFFFF→0x0000.
- **Reset** (asserted anytime, including mid-STEP or mid-debounce):
  - `work_ena`=0, `mode`=00, `btn_pulse`=0, `disp_sel`=0, `cycle_cnt`=0.
  - Synchronisers, stable flags, debounce counters and slow counter all 0.
  - A button held through reset release is seen as a new press after debounce.

## Timing
- Raw button stable from edge k:
  - `sync` = 1 after edge k+2.
  - `stable` = 1 after edge k+2+`DB_TICKS`.
  - `btn_pulse` high during the cycle after edge k+3+`DB_TICKS`.
- The FSM transition and the new `work_ena` value both take effect on the edge that ends the pulse cycle. `mode` and `work_ena` therefore change together, one cycle after the pulse.
- STEP lasts exactly one cycle, so exactly one `work_ena`=1 cycle is produced per R press from PAUSE.
- SLOW entered at edge e: first `work_ena`=1 during the cycle after edge e+`SLOW_DIV`−1, then every `SLOW_DIV` cycles.
- `cycle_cnt` lags `work_ena` by one cycle.

## Test plan
Parameters for all scenarios: `DB_TICKS`=4, `SLOW_DIV`=8.
1. **Reset and glitch rejection.** Reset, then apply a 3-cycle btnC glitch.
   - Required: all outputs stay 0; no pulse; `mode`=00.
2. **RUN / PAUSE toggle.** Hold btnC for 20 cycles.
   - Required: a single `btn_pulse[0]` 7 cycles after the raw rise; `mode`=01 and `work_ena`=1 from the next cycle.
   - Second press → `mode`=00 and `work_ena`=0. `cycle_cnt` equals the number of RUN cycles.
3. **STEP.** In PAUSE, press btnR three times.
   - Required: exactly three isolated `work_ena` cycles; `mode` shows 10 for one cycle each time; `cycle_cnt`=3.
4. **SLOW mode.** Press btnU from PAUSE and run 40 cycles.
   - Required: `work_ena` pulses on every 8th cycle, first at 8 cycles after entry; `cycle_cnt`=5.
   - btnU again → RUN.
5. **Simultaneous presses.** btnC and btnR pressed in the same cycle from PAUSE → RUN (C wins).
   - btnL and btnD together → `disp_sel` unchanged.
   - btnL alone from 0 → 3.
6. **Wrap and mid-operation reset.**
   - Force RUN for 65 536+2 cycles → `cycle_cnt` wraps to 2.
   - Assert `rst_n`=0 mid-RUN → `work_ena`, `mode` and `cycle_cnt` go to 0 immediately (asynchronous).

Source files
------------

// File: rtl/run_step_ctrl.sv
// Run/step execution controller: debounced push-buttons drive a PAUSE/RUN/STEP/SLOW
// mode FSM that gates the CPU core through work_ena.

module run_step_db #(
    parameter int DB_TICKS = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DB_TICKS + 1);

    logic [1:0]    sync_ff;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          stable_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff  <= '0;
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[0], btn};
            stable_d <= stable;
            pulse    <= stable & ~stable_d;
            // The edge that would bring the count to DB_TICKS accepts the level instead.
            if (sync_ff[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_TICKS - 1)) begin
                stable <= sync_ff[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module run_step_ctrl #(
    parameter int DB_TICKS = 1_000_000,
    parameter int SLOW_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btnC,
    input  logic        btnU,
    input  logic        btnL,
    input  logic        btnR,
    input  logic        btnD,
    output logic        work_ena,
    output logic [1:0]  mode,
    output logic [4:0]  btn_pulse,
    output logic [1:0]  disp_sel,
    output logic [15:0] cycle_cnt
);
    localparam int NUM_BTN = 5;
    localparam int SW      = $clog2(SLOW_DIV);

    typedef enum logic [1:0] {
        PAUSE = 2'b00,
        RUN   = 2'b01,
        STEP  = 2'b10,
        SLOW  = 2'b11
    } mode_e;

    logic [NUM_BTN-1:0] btn_raw;
    mode_e              state_q, state_d;
    logic [SW-1:0]      slow_q, slow_d;
    logic               ena_d;
    logic [1:0]         disp_d;

    assign btn_raw = {btnD, btnR, btnL, btnU, btnC};
    assign mode    = state_q;

    run_step_db #(.DB_TICKS(DB_TICKS)) u_db [NUM_BTN-1:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_raw),
        .pulse (btn_pulse)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            PAUSE: begin
                if (btn_pulse[0])      state_d = RUN;
                else if (btn_pulse[1]) state_d = SLOW;
                else if (btn_pulse[3]) state_d = STEP;
            end
            RUN: begin
                if (btn_pulse[0])      state_d = PAUSE;
                else if (btn_pulse[1]) state_d = SLOW;
            end
            SLOW: begin
                if (btn_pulse[0])      state_d = PAUSE;
                else if (btn_pulse[1]) state_d = RUN;
            end
            default: state_d = PAUSE;
        endcase

        // Entering SLOW restarts the divider; it only advances while staying in SLOW.
        slow_d = '0;
        if (state_d == SLOW && state_q == SLOW)
            slow_d = (slow_q == SW'(SLOW_DIV - 1)) ? '0 : slow_q + 1'b1;

        ena_d = (state_d == RUN) || (state_d == STEP) ||
                (state_d == SLOW && slow_d == SW'(SLOW_DIV - 1));

        disp_d = disp_sel;
        if (btn_pulse[4] && !btn_pulse[2])      disp_d = disp_sel + 2'd1;
        else if (btn_pulse[2] && !btn_pulse[4]) disp_d = disp_sel - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PAUSE;
            slow_q    <= '0;
            work_ena  <= 1'b0;
            disp_sel  <= '0;
            cycle_cnt <= '0;
        end else begin
            state_q  <= state_d;
            slow_q   <= slow_d;
            work_ena <= ena_d;
            disp_sel <= disp_d;
            if (work_ena) cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_run_step_ctrl.sv
// Directed bench for run_step_ctrl with DB_TICKS=4, SLOW_DIV=8; inputs driven and
// outputs sampled on the falling clock edge.

module tb_run_step_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btnC = 0, btnU = 0, btnL = 0, btnR = 0, btnD = 0;
    logic        work_ena;
    logic [1:0]  mode;
    logic [4:0]  btn_pulse;
    logic [1:0]  disp_sel;
    logic [15:0] cycle_cnt;

    int n_vec = 0;
    int n_err = 0;

    run_step_ctrl #(.DB_TICKS(4), .SLOW_DIV(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btnC      (btnC),
        .btnU      (btnU),
        .btnL      (btnL),
        .btnR      (btnR),
        .btnD      (btnD),
        .work_ena  (work_ena),
        .mode      (mode),
        .btn_pulse (btn_pulse),
        .disp_sel  (disp_sel),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_btns(input logic [4:0] b);
        {btnD, btnR, btnL, btnU, btnC} = b;
    endtask

    // Raw press at the current falling edge; the pulse is visible 7 cycles later.
    task automatic press(input logic [4:0] b, input string tag);
        set_btns(b);
        step(6);
        chk({tag, "_pre_pulse"}, 32'(btn_pulse), 32'h0);
        step(1);
        chk({tag, "_pulse"}, 32'(btn_pulse), 32'(b));
        set_btns(5'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // 1. reset state and glitch rejection
        step(2);
        chk("rst_work_ena", 32'(work_ena), 32'h0);
        chk("rst_mode", 32'(mode), 32'h0);
        chk("rst_pulse", 32'(btn_pulse), 32'h0);
        chk("rst_disp", 32'(disp_sel), 32'h0);
        chk("rst_cnt", 32'(cycle_cnt), 32'h0);
        rst_n = 1'b1;
        step(2);
        btnC = 1'b1;
        step(3);
        btnC = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("glitch_pulse", 32'(btn_pulse), 32'h0);
        end
        chk("glitch_mode", 32'(mode), 32'h0);
        chk("glitch_ena", 32'(work_ena), 32'h0);

        // 2. RUN / PAUSE toggle
        press(5'b00001, "run_on");
        step(1);
        chk("run_mode", 32'(mode), 32'h1);
        chk("run_ena", 32'(work_ena), 32'h1);
        chk("run_single_pulse", 32'(btn_pulse), 32'h0);
        step(22);
        chk("run_hold_mode", 32'(mode), 32'h1);
        press(5'b00001, "run_off");
        step(1);
        chk("pause_mode", 32'(mode), 32'h0);
        chk("pause_ena", 32'(work_ena), 32'h0);
        chk("run_cycles", 32'(cycle_cnt), 32'd30);
        step(10);
        chk("pause_cnt_hold", 32'(cycle_cnt), 32'd30);

        // 3. STEP, three isolated presses
        do_reset();
        for (int k = 0; k < 3; k++) begin
            press(5'b01000, "step");
            chk("step_ena_before", 32'(work_ena), 32'h0);
            step(1);
            chk("step_mode", 32'(mode), 32'h2);
            chk("step_ena", 32'(work_ena), 32'h1);
            step(1);
            chk("step_back_mode", 32'(mode), 32'h0);
            chk("step_back_ena", 32'(work_ena), 32'h0);
            step(10);
        end
        chk("step_cnt", 32'(cycle_cnt), 32'd3);

        // 4. SLOW mode
        do_reset();
        press(5'b00010, "slow_on");
        step(1);
        chk("slow_mode", 32'(mode), 32'h3);
        for (int j = 0; j < 40; j++) begin
            chk("slow_ena", 32'(work_ena), 32'((j % 8) == 7));
            step(1);
        end
        chk("slow_cnt", 32'(cycle_cnt), 32'd5);
        press(5'b00010, "slow_off");
        step(1);
        chk("slow_to_run_mode", 32'(mode), 32'h1);
        chk("slow_to_run_ena", 32'(work_ena), 32'h1);

        // 5. simultaneous presses and display page
        do_reset();
        press(5'b01001, "c_and_r");
        step(1);
        chk("c_wins_mode", 32'(mode), 32'h1);
        step(10);
        press(5'b10100, "l_and_d");
        step(1);
        chk("l_and_d_disp", 32'(disp_sel), 32'h0);
        step(10);
        press(5'b00100, "l_only");
        step(1);
        chk("l_wrap_disp", 32'(disp_sel), 32'h3);
        step(10);
        press(5'b10000, "d_only");
        step(1);
        chk("d_wrap_disp", 32'(disp_sel), 32'h0);

        // 6. counter wrap and asynchronous reset mid-RUN
        do_reset();
        press(5'b00001, "wrap_run");
        step(1);
        chk("wrap_start_cnt", 32'(cycle_cnt), 32'h0);
        step(65538);
        chk("wrap_cnt", 32'(cycle_cnt), 32'd2);
        chk("wrap_mode", 32'(mode), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ena", 32'(work_ena), 32'h0);
        chk("async_mode", 32'(mode), 32'h0);
        chk("async_cnt", 32'(cycle_cnt), 32'h0);
        btnC = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(6);
        chk("held_pre_pulse", 32'(btn_pulse), 32'h0);
        step(1);
        chk("held_pulse", 32'(btn_pulse), 32'h1);
        btnC = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
